// File: rtl/sync_meas_if.sv
// sync_meas_if: result handoff bundle of sync_meas_ctrl.
// master = result producer, slave = host-side consumer.
interface sync_meas_if;
  logic [31:0] res_min0;
  logic [31:0] res_min1;
  logic [31:0] res_min2;
  logic [31:0] res_max0;
  logic [31:0] res_max1;
  logic [31:0] res_max2;
  logic [2:0]  res_fault;
  logic [2:0]  res_miss;
  logic        res_valid;
  logic        res_ready;

  modport master (
    output res_min0, res_min1, res_min2,
    output res_max0, res_max1, res_max2,
    output res_fault, res_miss, res_valid,
    input  res_ready
  );

  modport slave (
    input  res_min0, res_min1, res_min2,
    input  res_max0, res_max1, res_max2,
    input  res_fault, res_miss, res_valid,
    output res_ready
  );
endinterface

// File: rtl/sync_meas_ctrl.sv
// sync_meas_ctrl: window sequencer for the sync-interval counter.
// Optional sticky fault flags: define SYNC_MEAS_STICKY_EN.
module sync_meas_ctrl #(
  parameter int unsigned WIN_CYC    = 48_000_000,
  parameter int unsigned CLR_CYC    = 2,
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned TOL        = 16,
  parameter int unsigned WCNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  output logic              meas_clr_n,
  input  logic [31:0]       min0,
  input  logic [31:0]       min1,
  input  logic [31:0]       min2,
  input  logic [31:0]       max0,
  input  logic [31:0]       max1,
  input  logic [31:0]       max2,
  input  logic [31:0]       exp0,
  input  logic [31:0]       exp1,
  input  logic [31:0]       exp2,
  sync_meas_if.master       res,
  output logic              busy,
  output logic [WCNT_W-1:0] win_cnt,
  input  logic              clr_sticky,
  output logic [2:0]        fault_sticky
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SETTLE,
    RUN,
    CAPTURE,
    REPORT
  } state_t;

  localparam logic [31:0] CLR_LD = 32'(CLR_CYC - 1);
  localparam logic [31:0] SET_LD =
    (SETTLE_CYC == 0) ? 32'd0 : 32'(SETTLE_CYC - 1);
  localparam logic [31:0] WIN_LD = 32'(WIN_CYC - 1);
  localparam bit NO_SETTLE = (SETTLE_CYC == 0);

  state_t      state;
  logic [31:0] cnt;
  logic [2:0]  miss_c;
  logic [2:0]  fault_c;

  // Upper bound kept in 33 bits, lower bound floors at zero.
  function automatic logic out_tol(
    input logic [31:0] mn,
    input logic [31:0] mx,
    input logic [31:0] ex
  );
    logic [32:0] hi;
    logic [31:0] lo;
    hi = {1'b0, ex} + 33'(TOL);
    lo = (ex < 32'(TOL)) ? 32'd0 : ex - 32'(TOL);
    return ({1'b0, mx} > hi) || (mn < lo);
  endfunction

  // Per-channel verdict on the live counter values.
  always_comb begin
    miss_c     = '0;
    fault_c    = '0;
    miss_c[0]  = (max0 == 32'd0);
    miss_c[1]  = (max1 == 32'd0);
    miss_c[2]  = (max2 == 32'd0);
    fault_c[0] = !miss_c[0] && out_tol(min0, max0, exp0);
    fault_c[1] = !miss_c[1] && out_tol(min1, max1, exp1);
    fault_c[2] = !miss_c[2] && out_tol(min2, max2, exp2);
  end

  // Window sequencer; abort overrides every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      meas_clr_n    <= 1'b1;
      busy          <= 1'b0;
      win_cnt       <= '0;
      res.res_min0  <= '0;
      res.res_min1  <= '0;
      res.res_min2  <= '0;
      res.res_max0  <= '0;
      res.res_max1  <= '0;
      res.res_max2  <= '0;
      res.res_fault <= '0;
      res.res_miss  <= '0;
      res.res_valid <= 1'b0;
    end else if (abort) begin
      state         <= IDLE;
      cnt           <= '0;
      meas_clr_n    <= 1'b1;
      busy          <= 1'b0;
      res.res_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state      <= CLR;
            cnt        <= CLR_LD;
            meas_clr_n <= 1'b0;
            busy       <= 1'b1;
          end
        end
        CLR: begin
          if (cnt == 32'd0) begin
            meas_clr_n <= 1'b1;
            if (NO_SETTLE) begin
              state <= RUN;
              cnt   <= WIN_LD;
            end else begin
              state <= SETTLE;
              cnt   <= SET_LD;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        SETTLE: begin
          if (cnt == 32'd0) begin
            state <= RUN;
            cnt   <= WIN_LD;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        RUN: begin
          if (cnt == 32'd0) begin
            state <= CAPTURE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end
        CAPTURE: begin
          res.res_min0  <= min0;
          res.res_min1  <= min1;
          res.res_min2  <= min2;
          res.res_max0  <= max0;
          res.res_max1  <= max1;
          res.res_max2  <= max2;
          res.res_fault <= fault_c;
          res.res_miss  <= miss_c;
          res.res_valid <= 1'b1;
          win_cnt       <= win_cnt + 1'b1;
          state         <= REPORT;
        end
        REPORT: begin
          if (res.res_ready) begin
            res.res_valid <= 1'b0;
            if (cont) begin
              state      <= CLR;
              cnt        <= CLR_LD;
              meas_clr_n <= 1'b0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          meas_clr_n <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SYNC_MEAS_STICKY_EN
  // Accumulate fault/miss per channel; a fresh set beats a clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_sticky <= '0;
    end else if (state == CAPTURE && !abort) begin
      fault_sticky <= (clr_sticky ? 3'b000 : fault_sticky)
                    | fault_c | miss_c;
    end else if (clr_sticky) begin
      fault_sticky <= '0;
    end
  end
`else
  logic unused_clr_sticky;

  assign unused_clr_sticky = clr_sticky;
  assign fault_sticky      = '0;
`endif

endmodule

// File: tb/tb_sync_meas_ctrl.sv
// tb_sync_meas_ctrl: table vectors, random windows vs reference model,
// and hand sequences for backpressure, abort and async reset.
module tb_sync_meas_ctrl;
  localparam int WIN  = 1000;
  localparam int CLRC = 2;
  localparam int SETC = 4;
  localparam int TOLV = 16;
  localparam int WW   = 4;
  localparam int LAT  = 1 + CLRC + SETC + WIN + 1;
`ifdef SYNC_MEAS_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cont;
  logic          abort;
  logic          clr_sticky;
  logic          meas_clr_n;
  logic          busy;
  logic [WW-1:0] win_cnt;
  logic [2:0]    fault_sticky;
  logic [31:0]   mn [3];
  logic [31:0]   mx [3];
  logic [31:0]   ex [3];

  sync_meas_if res ();

  sync_meas_ctrl #(
    .WIN_CYC    (WIN),
    .CLR_CYC    (CLRC),
    .SETTLE_CYC (SETC),
    .TOL        (TOLV),
    .WCNT_W     (WW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cont         (cont),
    .abort        (abort),
    .meas_clr_n   (meas_clr_n),
    .min0         (mn[0]),
    .min1         (mn[1]),
    .min2         (mn[2]),
    .max0         (mx[0]),
    .max1         (mx[1]),
    .max2         (mx[2]),
    .exp0         (ex[0]),
    .exp1         (ex[1]),
    .exp2         (ex[2]),
    .res          (res),
    .busy         (busy),
    .win_cnt      (win_cnt),
    .clr_sticky   (clr_sticky),
    .fault_sticky (fault_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0][31:0] ex;
    logic [2:0][31:0] mn;
    logic [2:0][31:0] mx;
    logic [2:0]       f;
    logic [2:0]       m;
  } vec_t;

  vec_t tbl [6];
  int   nchk = 0;
  int   nerr = 0;
  int   mcnt = 0;
  logic [2:0] mst = 3'b000;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rmin(input int i);
    case (i)
      0:       return res.res_min0;
      1:       return res.res_min1;
      default: return res.res_min2;
    endcase
  endfunction

  function automatic logic [31:0] rmax(input int i);
    case (i)
      0:       return res.res_max0;
      1:       return res.res_max1;
      default: return res.res_max2;
    endcase
  endfunction

  // Reference verdict straight from the tolerance rule.
  function automatic void model(output logic [2:0] f,
                                output logic [2:0] m);
    longint e, lo, hi, vmx, vmn;
    f = '0;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      e   = {32'd0, ex[i]};
      vmx = {32'd0, mx[i]};
      vmn = {32'd0, mn[i]};
      lo  = e - TOLV;
      if (lo < 0) lo = 0;
      hi   = e + TOLV;
      m[i] = (vmx == 0);
      f[i] = !m[i] && ((vmx > hi) || (vmn < lo));
    end
  endfunction

  task automatic check_res(input string nm, input bit clr_cap);
    logic [2:0] f, m;
    model(f, m);
    mcnt = (mcnt + 1) % (1 << WW);
    if (STICKY) mst = (clr_cap ? 3'b000 : mst) | f | m;
    chk({nm, " valid"}, res.res_valid, 1);
    chk({nm, " fault"}, res.res_fault, f);
    chk({nm, " miss"}, res.res_miss, m);
    chk({nm, " win_cnt"}, win_cnt, mcnt);
    chk({nm, " sticky"}, fault_sticky, mst);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s min%0d", nm, i), rmin(i), mn[i]);
      chk($sformatf("%s max%0d", nm, i), rmax(i), mx[i]);
    end
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!res.res_valid && cyc < LAT + 200) begin
      tick();
      cyc++;
    end
  endtask

  // Single-shot window with res_ready=1 and cont=0.
  task automatic run_win(input string nm, input bit clr_cap);
    int cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (!res.res_valid && cyc < LAT + 200) begin
      if (cyc <= CLRC + 1)
        chk($sformatf("%s clr_n@%0d", nm, cyc), meas_clr_n,
            (cyc <= CLRC) ? 0 : 1);
      clr_sticky = clr_cap && (cyc == LAT - 1);
      tick();
      cyc++;
    end
    clr_sticky = 1'b0;
    chk({nm, " latency"}, cyc, LAT);
    check_res(nm, clr_cap);
    tick();
    chk({nm, " valid_drop"}, res.res_valid, 0);
    chk({nm, " idle"}, busy, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    bit          bad;
    logic [31:0] s_min0, s_max1;
    logic [2:0]  s_flt, s_miss;
    logic [WW-1:0] s_cnt;

    tbl[0] = '{ex: {32'd10, 32'd100, 32'd100},
               mn: {32'd0, 32'd100, 32'd84},
               mx: {32'd20, 32'd117, 32'd116},
               f: 3'b010, m: 3'b000};
    tbl[1] = '{ex: {32'd10, 32'd100, 32'd100},
               mn: {32'd0, 32'd0, 32'd84},
               mx: {32'd20, 32'd0, 32'd116},
               f: 3'b000, m: 3'b010};
    tbl[2] = '{ex: {32'd0, 32'd32, 32'd5},
               mn: {32'd0, 32'd15, 32'd0},
               mx: {32'd16, 32'd32, 32'd22},
               f: 3'b011, m: 3'b000};
    tbl[3] = '{ex: {32'd17, 32'd16, 32'hFFFF_FFF8},
               mn: {32'd0, 32'd0, 32'hFFFF_FFE8},
               mx: {32'd33, 32'd32, 32'hFFFF_FFFF},
               f: 3'b100, m: 3'b000};
    tbl[4] = '{ex: {32'd50, 32'd50, 32'd50},
               mn: {32'd5, 32'd5, 32'd5},
               mx: {32'd0, 32'd0, 32'd0},
               f: 3'b000, m: 3'b111};
    tbl[5] = '{ex: {32'd3000, 32'd2000, 32'd1000},
               mn: {32'd3000, 32'd1984, 32'd983},
               mx: {32'd3000, 32'd2017, 32'd1016},
               f: 3'b011, m: 3'b000};

    rst        = 1'b0;
    start      = 1'b1;
    cont       = 1'b0;
    abort      = 1'b0;
    clr_sticky = 1'b0;
    res.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mn[i] = '0;
      mx[i] = '0;
      ex[i] = '0;
    end
    repeat (3) tick();
    chk("rst clr_n", meas_clr_n, 1);
    chk("rst busy", busy, 0);
    chk("rst valid", res.res_valid, 0);
    chk("rst win_cnt", win_cnt, 0);
    chk("rst fault", res.res_fault, 0);
    chk("rst min0", res.res_min0, 0);
    chk("rst sticky", fault_sticky, 0);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    chk("post_rst busy", busy, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 3; i++) begin
        ex[i] = tbl[k].ex[i];
        mn[i] = tbl[k].mn[i];
        mx[i] = tbl[k].mx[i];
      end
      run_win($sformatf("tbl%0d", k), 1'b0);
      chk($sformatf("tbl%0d fault_const", k), res.res_fault, tbl[k].f);
      chk($sformatf("tbl%0d miss_const", k), res.res_miss, tbl[k].m);
    end

    cont          = 1'b1;
    res.res_ready = 1'b0;
    start         = 1'b1;
    tick();
    start = 1'b0;
    wait_valid(cyc);
    chk("cont1 latency", cyc + 1, LAT);
    check_res("cont1", 1'b0);
    s_min0 = res.res_min0;
    s_max1 = res.res_max1;
    s_flt  = res.res_fault;
    s_miss = res.res_miss;
    s_cnt  = win_cnt;
    bad    = 1'b0;
    for (int j = 0; j < 50; j++) begin
      mn[0] = mn[0] + 32'd1;
      mx[1] = mx[1] + 32'd3;
      tick();
      if (!res.res_valid || res.res_min0 !== s_min0 ||
          res.res_max1 !== s_max1 || res.res_fault !== s_flt ||
          res.res_miss !== s_miss || win_cnt !== s_cnt || !busy)
        bad = 1'b1;
    end
    chk("bp stable", bad, 0);
    res.res_ready = 1'b1;
    tick();
    chk("cont accept valid", res.res_valid, 0);
    chk("cont accept clr_n", meas_clr_n, 0);
    chk("cont accept busy", busy, 1);
    wait_valid(cyc);
    chk("cont2 latency", cyc, LAT - 1);
    check_res("cont2", 1'b0);
    tick();
    chk("cont2 reclr", meas_clr_n, 0);
    cont = 1'b0;
    wait_valid(cyc);
    chk("cont3 latency", cyc, LAT - 1);
    check_res("cont3", 1'b0);
    tick();
    chk("cont3 idle", busy, 0);
    chk("cont3 valid_drop", res.res_valid, 0);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        ex[i] = $urandom_range(5000, 20);
        if ($urandom_range(4, 0) == 0) mx[i] = 32'd0;
        else mx[i] = ex[i] + $urandom_range(40, 0) - 32'd20;
        mn[i] = ex[i] - 32'd20 + $urandom_range(40, 0);
      end
      run_win($sformatf("rnd%0d", k), 1'b0);
    end

    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start+abort busy", busy, 0);
    chk("start+abort clr_n", meas_clr_n, 1);

    s_min0 = res.res_min0;
    start  = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < 1 + CLRC + SETC + 500) begin
      tick();
      cyc++;
    end
    chk("abort_run busy_before", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_run busy", busy, 0);
    chk("abort_run clr_n", meas_clr_n, 1);
    chk("abort_run valid", res.res_valid, 0);
    chk("abort_run win_cnt", win_cnt, mcnt);
    bad = 1'b0;
    repeat (WIN + 100) begin
      tick();
      if (res.res_valid || busy) bad = 1'b1;
    end
    chk("abort_run quiet", bad, 0);

    ex[0] = 32'd100;
    ex[1] = 32'd100;
    ex[2] = 32'd10;
    mn[0] = 32'hDEAD_0001;
    mn[1] = 32'd100;
    mn[2] = 32'd10;
    mx[0] = 32'd100;
    mx[1] = 32'd100;
    mx[2] = 32'd100;
    s_min0 = res.res_min0;
    s_flt  = res.res_fault;
    start  = 1'b1;
    tick();
    start = 1'b0;
    cyc   = 1;
    while (cyc < LAT - 1) begin
      tick();
      cyc++;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_cap min0", res.res_min0, s_min0);
    chk("abort_cap fault", res.res_fault, s_flt);
    chk("abort_cap win_cnt", win_cnt, mcnt);
    chk("abort_cap valid", res.res_valid, 0);
    chk("abort_cap busy", busy, 0);
    chk("abort_cap sticky", fault_sticky, mst);

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("arst pre clr_n", meas_clr_n, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("arst clr_n", meas_clr_n, 1);
    chk("arst busy", busy, 0);
    chk("arst win_cnt", win_cnt, 0);
    chk("arst valid", res.res_valid, 0);
    chk("arst min0", res.res_min0, 0);
    chk("arst fault", res.res_fault, 0);
    chk("arst sticky", fault_sticky, 0);
    start = 1'b1;
    repeat (3) tick();
    chk("arst start_ignored", busy, 0);
    start = 1'b0;
    rst   = 1'b1;
    mcnt  = 0;
    mst   = 3'b000;
    tick();
    chk("arst release busy", busy, 0);

    mn[0] = 32'd100;
    run_win("stk_fault", 1'b0);
    mx[2] = 32'd10;
    run_win("stk_clean", 1'b0);
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    mst = 3'b000;
    chk("stk clr", fault_sticky, mst);
    mx[2] = 32'd100;
    run_win("stk_coin", 1'b1);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
